// File: rtl/banked_array_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types (shared cache types package, banked_array slice)
//
// Purpose : Shared cache-datapath types. Holds the banked_array sweep state so
//           cache controllers can name it in their own assertions.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package lc3b_types;

   // Bits per byte lane of a storage word.
   localparam int unsigned ARR_BYTE_W = 8;

   // Sweep FSM state of banked_array.
   typedef enum logic {
      ARR_IDLE,
      ARR_CLEAR
   } arr_state_t;

endpackage : lc3b_types

// File: rtl/banked_array_merge.sv
// -----------------------------------------------------------------------------
// byte_merge
//
// Purpose : Combinational byte-lane merge. Lane i of the result takes i_new
//           when i_be[i] is set and keeps i_old otherwise. Shared with the
//           cache write path.
// Ports   : i_old    [WIDTH-1:0]   current word
//           i_new    [WIDTH-1:0]   incoming word
//           i_be     [WIDTH/8-1:0] byte enables, bit i covers bits [8i+7:8i]
//           o_merged [WIDTH-1:0]   merged word
// -----------------------------------------------------------------------------
module byte_merge
   import lc3b_types::*;
#(
   parameter int unsigned WIDTH = 128
) (
   input  logic [WIDTH-1:0]            i_old,
   input  logic [WIDTH-1:0]            i_new,
   input  logic [WIDTH/ARR_BYTE_W-1:0] i_be,
   output logic [WIDTH-1:0]            o_merged
);

   localparam int unsigned BE_W = WIDTH / ARR_BYTE_W;

   for (genvar g = 0; g < BE_W; g++) begin : g_lane
      assign o_merged[g*ARR_BYTE_W +: ARR_BYTE_W] =
         i_be[g] ? i_new[g*ARR_BYTE_W +: ARR_BYTE_W] : i_old[g*ARR_BYTE_W +: ARR_BYTE_W];
   end

endmodule : byte_merge

// File: rtl/banked_array.sv
// -----------------------------------------------------------------------------
// banked_array
//
// Purpose : Flip-flop storage array for cache data/tag/valid-dirty arrays with
//           independent read and write indices, per-byte write enables and a
//           runtime clear sweep that writes CLEAR_VAL to every entry, one entry
//           per cycle.
//
// Config  : BANKED_ARRAY_RDREG_EN defined   -> registered read, one-cycle
//                                              latency, write-first on a
//                                              same-index read/write.
//           BANKED_ARRAY_RDREG_EN undefined -> combinational read (default).
//
// Ports   : clk         in   rising-edge clock
//           rst_n       in   asynchronous active-low reset
//           wr_en       in   write request (ignored while busy)
//           wr_index    in   write entry
//           wr_be       in   byte enables
//           wr_data     in   write data
//           rd_index    in   read entry
//           rd_data     out  read data (CLEAR_VAL while busy)
//           clear_start in   single-cycle request to start a clear sweep
//           busy        out  clear sweep in progress
//           done        out  one-cycle pulse the cycle after busy falls
// -----------------------------------------------------------------------------
module banked_array
   import lc3b_types::*;
#(
   parameter int unsigned     WIDTH     = 128,
   parameter int unsigned     DEPTH     = 8,
   parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
   localparam int unsigned    IDX_W     = $clog2(DEPTH),
   localparam int unsigned    BE_W      = WIDTH / 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [BE_W-1:0]  wr_be,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_index,
   output logic [WIDTH-1:0] rd_data,
   input  logic             clear_start,
   output logic             busy,
   output logic             done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   // Storage is plain flops so the whole array can be reset and swept.
   logic [WIDTH-1:0] r_mem [DEPTH];

   arr_state_t       r_state;
   arr_state_t       w_state_nxt;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_ptr_nxt;
   logic             r_done;
   logic             w_done_nxt;

   logic             w_busy;
   logic             w_wr_fire;
   logic [WIDTH-1:0] w_merged;

   assign w_busy = (r_state == ARR_CLEAR);

   // A clear request in the same cycle wins over a write; busy drops writes.
   assign w_wr_fire = wr_en && !w_busy && !clear_start;

   byte_merge #(
      .WIDTH (WIDTH)
   ) u_byte_merge (
      .i_old    (r_mem[wr_index]),
      .i_new    (wr_data),
      .i_be     (wr_be),
      .o_merged (w_merged)
   );

   // ---------------------------------------------------------------------------
   // Sweep FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARR_IDLE;
         r_ptr   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         ARR_IDLE: begin
            if (clear_start) begin
               w_state_nxt = ARR_CLEAR;
               w_ptr_nxt   = '0;
            end
         end
         ARR_CLEAR: begin
            // Pointer wraps naturally to 0 after the last entry.
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr == LAST_IDX) begin
               w_state_nxt = ARR_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_busy) begin
         r_mem[r_ptr] <= CLEAR_VAL;
      end else if (w_wr_fire) begin
         r_mem[wr_index] <= w_merged;
      end
   end

   // ---------------------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------------------
`ifdef BANKED_ARRAY_RDREG_EN
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else if (w_busy) begin
         r_rd_data <= CLEAR_VAL;
      end else if (w_wr_fire && (wr_index == rd_index)) begin
         // Write-first: capture the bytes being written this edge.
         r_rd_data <= w_merged;
      end else begin
         r_rd_data <= r_mem[rd_index];
      end
   end

   assign rd_data = r_rd_data;
`else
   assign rd_data = w_busy ? CLEAR_VAL : r_mem[rd_index];
`endif

   assign busy = w_busy;
   assign done = r_done;

endmodule : banked_array

// File: tb/tb_banked_array.sv
// -----------------------------------------------------------------------------
// tb_banked_array
//
// Self-checking bench for banked_array (WIDTH 128, DEPTH 8, CLEAR_VAL 0).
// Honours BANKED_ARRAY_RDREG_EN to match the DUT read latency.
// -----------------------------------------------------------------------------
module tb_banked_array;

   localparam int unsigned WIDTH = 128;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned BE_W  = 16;
   localparam logic [WIDTH-1:0] CLR = '0;

   logic             clk;
   logic             rst_n;
   logic             wr_en;
   logic [IDX_W-1:0] wr_index;
   logic [BE_W-1:0]  wr_be;
   logic [WIDTH-1:0] wr_data;
   logic [IDX_W-1:0] rd_index;
   logic [WIDTH-1:0] rd_data;
   logic             clear_start;
   logic             busy;
   logic             done;

   int n_cmp = 0;
   int n_err = 0;

   // Reference contents of the array.
   logic [WIDTH-1:0] model [DEPTH];

   banked_array #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .CLEAR_VAL (CLR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_index    (wr_index),
      .wr_be       (wr_be),
      .wr_data     (wr_data),
      .rd_index    (rd_index),
      .rd_data     (rd_data),
      .clear_start (clear_start),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic void model_write(input int idx, input logic [BE_W-1:0] be,
                                       input logic [WIDTH-1:0] data);
      for (int b = 0; b < int'(BE_W); b++) begin
         if (be[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < int'(DEPTH); i++) model[i] = CLR;
   endfunction

   // One write; the DUT sees it on the posedge between the two negedges.
   task automatic do_write(input int idx, input logic [BE_W-1:0] be,
                           input logic [WIDTH-1:0] data);
      @(negedge clk);
      wr_en    = 1'b1;
      wr_index = IDX_W'(idx);
      wr_be    = be;
      wr_data  = data;
      @(negedge clk);
      wr_en    = 1'b0;
      wr_be    = '0;
   endtask

   task automatic do_read(input int idx, output logic [WIDTH-1:0] data);
      @(negedge clk);
      rd_index = IDX_W'(idx);
`ifdef BANKED_ARRAY_RDREG_EN
      @(negedge clk);
`endif
      #1;
      data = rd_data;
   endtask

   task automatic test_reset();
      logic [WIDTH-1:0] d;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags: busy=%b done=%b, required busy=0 done=0", busy, done);
      end
      rst_n = 1'b1;
      model_clear();
      for (int i = 0; i < int'(DEPTH); i++) begin
         do_read(i, d);
         n_cmp++;
         if (d !== model[i]) begin
            n_err++;
            $display("FAIL reset_read[%0d]: got %h, required %h", i, d, model[i]);
         end
      end
   endtask

   task automatic test_byte_write();
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] exp_lit;
      exp_lit = 128'h00112233_44556677_8899AABB_CCDDFFFF;
      do_write(3, 16'hFFFF, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      model_write(3, 16'hFFFF, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      do_write(3, 16'h0003, '1);
      model_write(3, 16'h0003, '1);
      do_read(3, d);
      n_cmp++;
      if (d !== exp_lit || d !== model[3]) begin
         n_err++;
         $display("FAIL byte_write_idx3: got %h, required %h", d, exp_lit);
      end
      do_read(2, d);
      n_cmp++;
      if (d !== '0) begin
         n_err++;
         $display("FAIL byte_write_idx2: got %h, required 0", d);
      end
      // Random partial writes, including be = 0 no-ops.
      for (int k = 0; k < 24; k++) begin
         int               idx;
         logic [BE_W-1:0]  be;
         logic [WIDTH-1:0] data;
         idx  = int'($urandom_range(0, DEPTH - 1));
         be   = (k % 6 == 5) ? '0 : BE_W'($urandom());
         data = rand_word();
         do_write(idx, be, data);
         model_write(idx, be, data);
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         do_read(i, d);
         n_cmp++;
         if (d !== model[i]) begin
            n_err++;
            $display("FAIL rand_write[%0d]: got %h, required %h", i, d, model[i]);
         end
      end
   endtask

`ifndef BANKED_ARRAY_RDREG_EN
   // Combinational read: old value until the edge, new value after it.
   task automatic test_read_during_write();
      logic [WIDTH-1:0] old_v;
      logic [WIDTH-1:0] data;
      old_v = model[4];
      data  = rand_word();
      @(negedge clk);
      rd_index = 3'd4;
      wr_en    = 1'b1;
      wr_index = 3'd4;
      wr_be    = 16'h0F0F;
      wr_data  = data;
      #1;
      n_cmp++;
      if (rd_data !== old_v) begin
         n_err++;
         $display("FAIL rdw_before_edge: got %h, required %h", rd_data, old_v);
      end
      model_write(4, 16'h0F0F, data);
      @(negedge clk);
      wr_en = 1'b0;
      wr_be = '0;
      #1;
      n_cmp++;
      if (rd_data !== model[4]) begin
         n_err++;
         $display("FAIL rdw_after_edge: got %h, required %h", rd_data, model[4]);
      end
   endtask
`endif

   task automatic test_clear();
      logic [WIDTH-1:0] d;
      int busy_cnt;
      bit finished;
      bit early_done;
      for (int i = 0; i < int'(DEPTH); i++) begin
         d = rand_word() | 128'h1;
         do_write(i, '1, d);
         model_write(i, '1, d);
      end
      busy_cnt   = 0;
      finished   = 1'b0;
      early_done = 1'b0;
      @(negedge clk);
      rd_index    = 3'd6;
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      for (int c = 0; c < 40 && !finished; c++) begin
         #1;
         if (busy) begin
            busy_cnt++;
            if (done) early_done = 1'b1;
            if (busy_cnt == 3) begin
               wr_en    = 1'b1;
               wr_index = 3'd5;
               wr_be    = '1;
               wr_data  = rand_word();
            end
            if (busy_cnt == 4) begin
               wr_en = 1'b0;
               wr_be = '0;
               n_cmp++;
               if (rd_data !== CLR) begin
                  n_err++;
                  $display("FAIL clear_rd_busy: got %h, required %h", rd_data, CLR);
               end
            end
         end else begin
            finished = 1'b1;
            n_cmp++;
            if (done !== 1'b1) begin
               n_err++;
               $display("FAIL clear_done_pulse: done=%b, required 1", done);
            end
         end
         if (!finished) @(negedge clk);
      end
      n_cmp++;
      if (!finished || busy_cnt != int'(DEPTH) || early_done) begin
         n_err++;
         $display("FAIL clear_busy_len: busy cycles=%0d finished=%0b early_done=%0b, required %0d 1 0",
                  busy_cnt, finished, early_done, DEPTH);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL clear_done_width: done=%b, required 0", done);
      end
      model_clear();
      for (int i = 0; i < int'(DEPTH); i++) begin
         do_read(i, d);
         n_cmp++;
         if (d !== model[i]) begin
            n_err++;
            $display("FAIL clear_read[%0d]: got %h, required %h", i, d, model[i]);
         end
      end
   endtask

   task automatic test_clear_wins();
      logic [WIDTH-1:0] d;
      bit seen;
      d = rand_word();
      do_write(1, '1, d);
      model_write(1, '1, d);
      @(negedge clk);
      clear_start = 1'b1;
      wr_en       = 1'b1;
      wr_index    = 3'd1;
      wr_be       = '1;
      wr_data     = {16{8'hA5}};
      @(negedge clk);
      clear_start = 1'b0;
      wr_en       = 1'b0;
      wr_be       = '0;
      seen        = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         #1;
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL clear_wins_done: done seen=%0b, required 1", seen);
      end
      model_clear();
      do_read(1, d);
      n_cmp++;
      if (d !== model[1]) begin
         n_err++;
         $display("FAIL clear_wins_idx1: got %h, required %h", d, model[1]);
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic [WIDTH-1:0] d;
      int busy_cnt;
      bit stray;
      do_write(2, '1, rand_word());
      do_write(7, '1, rand_word());
      @(negedge clk);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 20 && busy_cnt < 4; c++) begin
         #1;
         if (busy) busy_cnt++;
         if (busy_cnt < 4) @(negedge clk);
      end
      n_cmp++;
      if (busy_cnt != 4) begin
         n_err++;
         $display("FAIL midreset_reach: busy cycles=%0d, required 4", busy_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_async: busy=%b done=%b, required 0 0", busy, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      stray = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         if (done || busy) stray = 1'b1;
      end
      n_cmp++;
      if (stray) begin
         n_err++;
         $display("FAIL midreset_no_done: busy/done seen=%0b, required 0", stray);
      end
      model_clear();
      for (int i = 0; i < int'(DEPTH); i++) begin
         do_read(i, d);
         n_cmp++;
         if (d !== model[i]) begin
            n_err++;
            $display("FAIL midreset_read[%0d]: got %h, required %h", i, d, model[i]);
         end
      end
      d = rand_word();
      do_write(7, '1, d);
      model_write(7, '1, d);
      do_read(7, d);
      n_cmp++;
      if (d !== model[7]) begin
         n_err++;
         $display("FAIL midreset_write7: got %h, required %h", d, model[7]);
      end
   endtask

`ifdef BANKED_ARRAY_RDREG_EN
   task automatic test_rdreg();
      logic [WIDTH-1:0] dead;
      logic [WIDTH-1:0] d3;
      dead = {4{32'hDEADBEEF}};
      d3   = rand_word();
      do_write(3, '1, d3);
      model_write(3, '1, d3);
      @(negedge clk);
      rd_index = 3'd0;
      wr_en    = 1'b1;
      wr_index = 3'd0;
      wr_be    = '1;
      wr_data  = dead;
      model_write(0, '1, dead);
      @(negedge clk);
      wr_en = 1'b0;
      wr_be = '0;
      #1;
      n_cmp++;
      if (rd_data !== model[0]) begin
         n_err++;
         $display("FAIL rdreg_write_first: got %h, required %h", rd_data, model[0]);
      end
      rd_index = 3'd3;
      #1;
      n_cmp++;
      if (rd_data !== model[0]) begin
         n_err++;
         $display("FAIL rdreg_latency_hold: got %h, required %h", rd_data, model[0]);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (rd_data !== model[3]) begin
         n_err++;
         $display("FAIL rdreg_latency_new: got %h, required %h", rd_data, model[3]);
      end
   endtask
`endif

   initial begin
      rst_n       = 1'b0;
      wr_en       = 1'b0;
      wr_index    = '0;
      wr_be       = '0;
      wr_data     = '0;
      rd_index    = '0;
      clear_start = 1'b0;
      model_clear();

      test_reset();
      test_byte_write();
`ifndef BANKED_ARRAY_RDREG_EN
      test_read_during_write();
`endif
      test_clear();
      test_clear_wins();
      test_reset_mid_sweep();
`ifdef BANKED_ARRAY_RDREG_EN
      test_rdreg();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_banked_array
